// File: rtl/defender_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : defender_input_pkg
//  Description : Shared constants for the Defender input conditioning stage:
//                button indices, PS/2 scancodes, held-key indices, coin FSM
//                state type and the scancode-to-key decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package defender_input_pkg;

    // Output button vector layout
    localparam int BTN_W                = 13;
    localparam int BTN_ADVANCE          = 0;
    localparam int BTN_AUTO_UP          = 1;
    localparam int BTN_HIGH_SCORE_RESET = 2;
    localparam int BTN_LEFT_COIN        = 3;
    localparam int BTN_ONE_PLAYER       = 4;
    localparam int BTN_TWO_PLAYERS      = 5;
    localparam int BTN_FIRE             = 6;
    localparam int BTN_THRUST           = 7;
    localparam int BTN_SMART_BOMB       = 8;
    localparam int BTN_HYPERSPACE       = 9;
    localparam int BTN_REVERSE          = 10;
    localparam int BTN_DOWN             = 11;
    localparam int BTN_UP               = 12;

    // PS/2 set-2 scancodes
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_6      = 8'h36;

    // One held bit per physical key, so keys sharing a function overlap cleanly
    localparam int KEY_W      = 18;
    localparam int KEY_UP     = 0;
    localparam int KEY_DOWN   = 1;
    localparam int KEY_LEFT   = 2;
    localparam int KEY_RIGHT  = 3;
    localparam int KEY_LSHIFT = 4;
    localparam int KEY_RSHIFT = 5;
    localparam int KEY_SPACE  = 6;
    localparam int KEY_F1     = 7;
    localparam int KEY_F2     = 8;
    localparam int KEY_CTRL   = 9;
    localparam int KEY_W_KEY  = 10;
    localparam int KEY_A      = 11;
    localparam int KEY_U      = 12;
    localparam int KEY_H      = 13;
    localparam int KEY_1      = 14;
    localparam int KEY_2      = 15;
    localparam int KEY_5      = 16;
    localparam int KEY_6      = 17;

    // Coin pulse shaper states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // One-hot key match for a scancode. Cursor keys and Ctrl accept either
    // E0 prefix state; every other key only matches the non-extended code.
    function automatic logic [KEY_W-1:0] key_decode(input logic ext, input logic [7:0] code);
        logic [KEY_W-1:0] hit;
        hit = '0;
        case (code)
            SC_UP:     hit[KEY_UP]     = 1'b1;
            SC_DOWN:   hit[KEY_DOWN]   = 1'b1;
            SC_LEFT:   hit[KEY_LEFT]   = 1'b1;
            SC_RIGHT:  hit[KEY_RIGHT]  = 1'b1;
            SC_CTRL:   hit[KEY_CTRL]   = 1'b1;
            SC_LSHIFT: hit[KEY_LSHIFT] = ~ext;
            SC_RSHIFT: hit[KEY_RSHIFT] = ~ext;
            SC_SPACE:  hit[KEY_SPACE]  = ~ext;
            SC_F1:     hit[KEY_F1]     = ~ext;
            SC_F2:     hit[KEY_F2]     = ~ext;
            SC_W:      hit[KEY_W_KEY]  = ~ext;
            SC_A:      hit[KEY_A]      = ~ext;
            SC_U:      hit[KEY_U]      = ~ext;
            SC_H:      hit[KEY_H]      = ~ext;
            SC_1:      hit[KEY_1]      = ~ext;
            SC_2:      hit[KEY_2]      = ~ext;
            SC_5:      hit[KEY_5]      = ~ext;
            SC_6:      hit[KEY_6]      = ~ext;
            default:   hit = '0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_coin_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_coin_pulse
//  Description : Turns a level coin request into a fixed-width pulse followed
//                by a forced-low lockout gap. Only a fresh rising edge seen
//                while idle starts a pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module arcade_coin_pulse
    import defender_input_pkg::*;
#(
    parameter int COIN_PULSE = 1_200_000,
    parameter int COIN_GAP   = 2_400_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req,
    output logic pulse
);

    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             w_req_rise;

    assign w_req_rise = req & ~req_q;

    // State register: FSM state, down-counter and request history
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next state: edges arriving outside IDLE are simply not looked at
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req;
        case (state_q)
            IDLE: begin
                if (w_req_rise) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output: coin line is high for exactly the cycles spent in PULSE
    always_comb begin
        pulse = (state_q == PULSE);
    end

endmodule
`default_nettype wire

// File: rtl/defender_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : defender_input_ctrl
//  Description : PS/2 key decoder, per-key held-state bank, joystick merge
//                and registered button vector for the Defender core. The
//                coin button is shaped by arcade_coin_pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module defender_input_ctrl
    import defender_input_pkg::*;
#(
    parameter int COIN_PULSE = 1_200_000,
    parameter int COIN_GAP   = 2_400_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [10:0]       ps2_key,
    input  logic [15:0]       joystick_0,
    input  logic [15:0]       joystick_1,
    output logic [BTN_W-1:0]  btn
);

    logic             tog_q, tog_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BTN_W-1:0] btn_q, btn_d;

    logic [15:0]      w_joy;
    logic             w_event;
    logic [KEY_W-1:0] w_key_hit;
    logic             w_coin_req;
    logic             w_coin_pulse;
    logic             w_unused;

    assign w_joy    = joystick_0 | joystick_1;
    assign w_unused = ^w_joy[15:10];

    // PS/2 decode: a toggle flip marks one event, which updates only the matching key
    always_comb begin
        tog_d     = ps2_key[10];
        w_event   = (ps2_key[10] != tog_q);
        w_key_hit = key_decode(ps2_key[8], ps2_key[7:0]);
        key_d     = key_q;
        for (int i = 0; i < KEY_W; i++) begin
            if (w_event && w_key_hit[i]) begin
                key_d[i] = ps2_key[9];
            end
        end
    end

    // Coin request: any coin key held or the joystick coin button
    always_comb begin
        w_coin_req = key_q[KEY_F1] | key_q[KEY_F2] | key_q[KEY_5] | key_q[KEY_6] | w_joy[9];
    end

    // Button equations from held keys and the merged joystick
    always_comb begin
        btn_d                       = '0;
        btn_d[BTN_ADVANCE]          = key_q[KEY_A];
        btn_d[BTN_AUTO_UP]          = key_q[KEY_U];
        btn_d[BTN_HIGH_SCORE_RESET] = key_q[KEY_H];
        btn_d[BTN_LEFT_COIN]        = w_coin_pulse;
        btn_d[BTN_ONE_PLAYER]       = key_q[KEY_F1] | key_q[KEY_1] | w_joy[8];
        btn_d[BTN_TWO_PLAYERS]      = key_q[KEY_F2] | key_q[KEY_2];
        btn_d[BTN_FIRE]             = key_q[KEY_SPACE] | w_joy[5];
        btn_d[BTN_THRUST]           = key_q[KEY_LEFT] | key_q[KEY_RIGHT] | w_joy[0] | w_joy[1];
        btn_d[BTN_SMART_BOMB]       = key_q[KEY_CTRL] | w_joy[6];
        btn_d[BTN_HYPERSPACE]       = key_q[KEY_W_KEY] | w_joy[7];
        btn_d[BTN_REVERSE]          = key_q[KEY_LSHIFT] | key_q[KEY_RSHIFT] | w_joy[4];
        btn_d[BTN_DOWN]             = key_q[KEY_DOWN] | w_joy[2];
        btn_d[BTN_UP]               = key_q[KEY_UP] | w_joy[3];
    end

    // Registers; reset samples the live toggle so no event is seen on release
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q <= ps2_key[10];
            key_q <= '0;
            btn_q <= '0;
        end else begin
            tog_q <= tog_d;
            key_q <= key_d;
            btn_q <= btn_d;
        end
    end

    assign btn = btn_q;

    arcade_coin_pulse #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (w_coin_req),
        .pulse   (w_coin_pulse)
    );

endmodule
`default_nettype wire

// File: tb/tb_defender_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_defender_input_ctrl
//  Description : Directed self-checking bench for defender_input_ctrl with
//                COIN_PULSE=4, COIN_GAP=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_defender_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic [12:0] btn;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    defender_input_ctrl #(
        .COIN_PULSE (4),
        .COIN_GAP   (3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .btn        (btn)
    );

    // Non-coin keys and the single button each one drives
    logic [8:0] key_codes [0:13] = '{9'h029, 9'h014, 9'h114, 9'h01D, 9'h012, 9'h059, 9'h072,
                                     9'h175, 9'h01C, 9'h03C, 9'h033, 9'h016, 9'h01E, 9'h16B};
    int         key_btn   [0:13] = '{6, 8, 8, 9, 10, 10, 11, 12, 0, 1, 2, 4, 5, 7};

    // Joystick vectors and the full button vector expected one cycle later
    logic [15:0] joy0_vec [0:6] = '{16'h0001, 16'h0000, 16'h0020, 16'h0000, 16'h0090, 16'h0008, 16'hFC00};
    logic [15:0] joy1_vec [0:6] = '{16'h0000, 16'h0004, 16'h0040, 16'h0100, 16'h0000, 16'h0002, 16'hFC00};
    logic [12:0] joy_exp  [0:6] = '{13'h0080, 13'h0800, 13'h0140, 13'h0010, 13'h0600, 13'h1080, 13'h0000};

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_send(input logic press, input logic [8:0] code);
        ps2_key = {~ps2_key[10], press, code};
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (btn !== 13'h0000) begin
            errors++;
            $display("FAIL reset_btn: got %h expected %h", btn, 13'h0000);
        end
    endtask

    task automatic test_joystick();
        for (int i = 0; i < 7; i++) begin
            joystick_0 = joy0_vec[i];
            joystick_1 = joy1_vec[i];
            tick();
            checks++;
            if (btn !== joy_exp[i]) begin
                errors++;
                $display("FAIL joystick[%0d]: got %h expected %h", i, btn, joy_exp[i]);
            end
        end
        joystick_0 = '0;
        joystick_1 = '0;
        tick();
    endtask

    task automatic test_thrust_overlap();
        ps2_send(1'b1, 9'h06B);
        tick();
        checks++;
        if (btn[7] !== 1'b0) begin
            errors++;
            $display("FAIL thrust_latency: got %b expected 0", btn[7]);
        end
        tick();
        checks++;
        if (btn !== 13'h0080) begin
            errors++;
            $display("FAIL thrust_left: got %h expected %h", btn, 13'h0080);
        end
        ps2_send(1'b1, 9'h074);
        tick();
        tick();
        ps2_send(1'b0, 9'h06B);
        tick();
        tick();
        checks++;
        if (btn !== 13'h0080) begin
            errors++;
            $display("FAIL thrust_right_held: got %h expected %h", btn, 13'h0080);
        end
        ps2_send(1'b0, 9'h074);
        tick();
        checks++;
        if (btn[7] !== 1'b1) begin
            errors++;
            $display("FAIL thrust_release_latency: got %b expected 1", btn[7]);
        end
        tick();
        checks++;
        if (btn !== 13'h0000) begin
            errors++;
            $display("FAIL thrust_released: got %h expected %h", btn, 13'h0000);
        end
    endtask

    task automatic test_keys();
        logic [12:0] exp;
        for (int i = 0; i < 14; i++) begin
            exp = '0;
            exp[key_btn[i]] = 1'b1;
            ps2_send(1'b1, key_codes[i]);
            tick();
            checks++;
            if (btn !== 13'h0000) begin
                errors++;
                $display("FAIL key_early[%h]: got %h expected %h", key_codes[i], btn, 13'h0000);
            end
            tick();
            checks++;
            if (btn !== exp) begin
                errors++;
                $display("FAIL key_press[%h]: got %h expected %h", key_codes[i], btn, exp);
            end
            ps2_send(1'b0, key_codes[i]);
            tick();
            tick();
            checks++;
            if (btn !== 13'h0000) begin
                errors++;
                $display("FAIL key_release[%h]: got %h expected %h", key_codes[i], btn, 13'h0000);
            end
        end
    endtask

    task automatic test_coin_pulse();
        logic exp;
        joystick_1 = 16'h0200;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k >= 2 && k <= 5);
            checks++;
            if (btn[3] !== exp) begin
                errors++;
                $display("FAIL coin_pulse[t%0d]: got %b expected %b", k, btn[3], exp);
            end
        end
        joystick_1 = '0;
        tick();
        tick();
    endtask

    task automatic test_coin_lockout();
        logic exp;
        joystick_0 = 16'h0200;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = (k >= 2 && k <= 5) || (k >= 10 && k <= 13);
            checks++;
            if (btn[3] !== exp) begin
                errors++;
                $display("FAIL coin_lockout[t%0d]: got %b expected %b", k, btn[3], exp);
            end
            if (k == 3 || k == 6 || k == 14) joystick_0 = '0;
            if (k == 5 || k == 8)            joystick_0 = 16'h0200;
        end
    endtask

    task automatic test_f1_combined();
        logic exp3;
        logic exp4;
        ps2_send(1'b1, 9'h005);
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp4 = (k >= 2 && k <= 8);
            exp3 = (k >= 3 && k <= 6);
            checks++;
            if (btn !== {8'h00, exp4, exp3, 3'b000}) begin
                errors++;
                $display("FAIL f1_combined[t%0d]: got %h expected %h", k, btn, {8'h00, exp4, exp3, 3'b000});
            end
            if (k == 7) ps2_send(1'b0, 9'h005);
        end
    endtask

    task automatic test_ignored_codes();
        ps2_send(1'b1, 9'h01C);
        tick();
        tick();
        ps2_send(1'b1, 9'h01A);
        tick();
        tick();
        checks++;
        if (btn !== 13'h0001) begin
            errors++;
            $display("FAIL ignored_unmapped: got %h expected %h", btn, 13'h0001);
        end
        ps2_send(1'b1, 9'h116);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (btn !== 13'h0001) begin
                errors++;
                $display("FAIL ignored_ext_1[t%0d]: got %h expected %h", k, btn, 13'h0001);
            end
        end
        ps2_send(1'b0, 9'h01C);
        tick();
        tick();
        checks++;
        if (btn !== 13'h0000) begin
            errors++;
            $display("FAIL ignored_cleanup: got %h expected %h", btn, 13'h0000);
        end
    endtask

    task automatic test_reset_midpulse();
        ps2_send(1'b1, 9'h029);
        tick();
        tick();
        joystick_0 = 16'h0200;
        tick();
        tick();
        checks++;
        if (btn !== 13'h0048) begin
            errors++;
            $display("FAIL midpulse_setup: got %h expected %h", btn, 13'h0048);
        end
        reset      = 1'b1;
        joystick_0 = '0;
        tick();
        checks++;
        if (btn !== 13'h0000) begin
            errors++;
            $display("FAIL midpulse_reset_edge: got %h expected %h", btn, 13'h0000);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (btn !== 13'h0000) begin
                errors++;
                $display("FAIL no_phantom[t%0d]: got %h expected %h", k, btn, 13'h0000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_joystick();
        test_thrust_overlap();
        test_keys();
        test_coin_pulse();
        test_coin_lockout();
        test_f1_combined();
        test_ignored_codes();
        test_reset_midpulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
